// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the 32-bit Ethernet header writer.
// Defining ETH_TX_PAD_EN adds the PAD state used for minimum-frame padding.
package eth_tx_pkg;

   localparam int DATA_WIDTH_DEF      = 32;
   localparam int MODULE_HDR_CTRL_DEF = 2;
   localparam int ETH_MIN_FRAME_BYTES = 60;

   localparam logic [3:0] CTRL_MID = 4'h0;
   localparam logic [3:0] CTRL_1B  = 4'h8;
   localparam logic [3:0] CTRL_2B  = 4'h4;
   localparam logic [3:0] CTRL_3B  = 4'h2;
   localparam logic [3:0] CTRL_4B  = 4'h1;

`ifdef ETH_TX_PAD_EN
   typedef enum logic [7:0] {
      IDLE    = 8'b0000_0001,
      MOD_HDR = 8'b0000_0010,
      HDR1    = 8'b0000_0100,
      HDR2    = 8'b0000_1000,
      HDR3    = 8'b0001_0000,
      PAYLOAD = 8'b0010_0000,
      TAIL    = 8'b0100_0000,
      PAD     = 8'b1000_0000
   } state_t;
`else
   typedef enum logic [6:0] {
      IDLE    = 7'b000_0001,
      MOD_HDR = 7'b000_0010,
      HDR1    = 7'b000_0100,
      HDR2    = 7'b000_1000,
      HDR3    = 7'b001_0000,
      PAYLOAD = 7'b010_0000,
      TAIL    = 7'b100_0000
   } state_t;
`endif

   // Valid bytes in a payload word; mid words count as full.
   function automatic logic [2:0] validBytes(input logic [3:0] ctrl);
      logic [2:0] n;
      case (ctrl)
         CTRL_1B: n = 3'd1;
         CTRL_2B: n = 3'd2;
         CTRL_3B: n = 3'd3;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/eth_tx_realign16.sv
// Shifts the payload stream by 16 bits behind the ethertype and translates
// the last-word ctrl into the output ctrl or a tail-word request.
module eth_tx_realign16
   import eth_tx_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic        i_shift,
   input  logic        i_clear,
   input  logic        i_zero_fill,
   input  logic [31:0] i_data,
   input  logic [3:0]  i_ctrl,
   output logic [31:0] o_word,
   output logic [31:0] o_tail_word,
   output logic        o_last,
   output logic [3:0]  o_out_ctrl,
   output logic        o_tail_req,
   output logic [3:0]  o_tail_ctrl
);

   logic [15:0] r_residue;
   logic [3:0]  r_tail_ctrl;
   logic [31:0] w_data;

   // Invalid bytes of a last word are zeroed only when the frame will be padded.
   always_comb begin
      w_data = i_data;
      if (i_zero_fill) begin
         case (i_ctrl)
            CTRL_1B: w_data = {i_data[31:24], 24'h0};
            CTRL_2B: w_data = {i_data[31:16], 16'h0};
            CTRL_3B: w_data = {i_data[31:8], 8'h0};
            default: w_data = i_data;
         endcase
      end
   end

   always_comb begin
      o_out_ctrl = CTRL_MID;
      case (i_ctrl)
         CTRL_1B: o_out_ctrl = CTRL_3B;
         CTRL_2B: o_out_ctrl = CTRL_4B;
         default: o_out_ctrl = CTRL_MID;
      endcase
   end

   assign o_word      = {r_residue, w_data[31:16]};
   assign o_tail_word = {r_residue, 16'h0};
   assign o_last      = (i_ctrl != CTRL_MID);
   assign o_tail_req  = (i_ctrl == CTRL_3B) || (i_ctrl == CTRL_4B);
   assign o_tail_ctrl = r_tail_ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_residue   <= 16'h0;
         r_tail_ctrl <= CTRL_MID;
      end else if (i_load) begin
         r_residue <= i_load_val;
      end else if (i_shift) begin
         r_residue <= w_data[15:0];
         if (o_tail_req)
            r_tail_ctrl <= (i_ctrl == CTRL_3B) ? CTRL_1B : CTRL_2B;
      end else if (i_clear) begin
         r_residue <= 16'h0;
      end
   end

endmodule

// File: rtl/ethernet_header_writer_32bit.sv
// Builds a NetFPGA-style packet: module header, 14-byte Ethernet header,
// then the payload realigned by 16 bits. ETH_TX_PAD_EN pads frames to 60 bytes.
module ethernet_header_writer_32bit
   import eth_tx_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int NUM_IQ_BITS     = 3,
   parameter int MODULE_HDR_CTRL = MODULE_HDR_CTRL_DEF
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hdr_valid,
   input  logic [47:0]            dst_mac,
   input  logic [47:0]            src_mac,
   input  logic [15:0]            ethertype,
   input  logic [NUM_IQ_BITS-1:0] src_port,
   output logic                   hdr_ack,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [CTRL_WIDTH-1:0]  in_ctrl,
   input  logic                   in_wr,
   output logic                   in_rdy,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [CTRL_WIDTH-1:0]  out_ctrl,
   output logic                   out_wr,
   input  logic                   out_rdy
);

   state_t r_state, w_state_next;

   logic [47:0]            r_dst_mac;
   logic [47:0]            r_src_mac;
   logic [15:0]            r_ethertype;
   logic [NUM_IQ_BITS-1:0] r_src_port;

   logic                  w_capture, w_emit, w_accept;
   logic                  w_load, w_clear, w_zero_fill;
   logic [DATA_WIDTH-1:0] w_word;
   logic [CTRL_WIDTH-1:0] w_ctrl;

   logic [31:0] w_rl_word, w_rl_tail_word;
   logic        w_rl_last, w_rl_tail_req;
   logic [3:0]  w_rl_out_ctrl, w_rl_tail_ctrl;

   assign in_rdy   = (r_state == PAYLOAD) && out_rdy;
   assign w_accept = in_wr && in_rdy;
   assign w_load   = (r_state == HDR3) && out_rdy;

`ifdef ETH_TX_PAD_EN
   logic [5:0] r_byte_cnt;
   logic [6:0] w_natural_total;
   logic       w_pad_needed, w_last_slot;

   // Counter holds Ethernet bytes already emitted and saturates at the minimum frame size.
   assign w_natural_total = {1'b0, r_byte_cnt} + 7'd2 + {4'b0, validBytes(in_ctrl)};
   assign w_pad_needed    = w_natural_total < 7'(ETH_MIN_FRAME_BYTES);
   assign w_last_slot     = ({1'b0, r_byte_cnt} + 7'd4) == 7'(ETH_MIN_FRAME_BYTES);
   assign w_zero_fill     = (r_state == PAYLOAD) && w_pad_needed;
   assign w_clear         = (r_state == PAD) && out_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_byte_cnt <= 6'd0;
      else if (w_capture)
         r_byte_cnt <= 6'd0;
      else if (w_emit && (r_state != MOD_HDR) && (r_byte_cnt < 6'(ETH_MIN_FRAME_BYTES)))
         r_byte_cnt <= r_byte_cnt + 6'd4;
   end
`else
   assign w_zero_fill = 1'b0;
   assign w_clear     = 1'b0;
`endif

   eth_tx_realign16 u_realign (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_load_val  (r_ethertype),
      .i_shift     (w_accept),
      .i_clear     (w_clear),
      .i_zero_fill (w_zero_fill),
      .i_data      (in_data),
      .i_ctrl      (in_ctrl),
      .o_word      (w_rl_word),
      .o_tail_word (w_rl_tail_word),
      .o_last      (w_rl_last),
      .o_out_ctrl  (w_rl_out_ctrl),
      .o_tail_req  (w_rl_tail_req),
      .o_tail_ctrl (w_rl_tail_ctrl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   // Every state except IDLE emits exactly one word per advancing cycle.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_emit       = 1'b0;
      w_word       = '0;
      w_ctrl       = '0;
      case (r_state)
         IDLE: begin
            if (hdr_valid) begin
               w_capture    = 1'b1;
               w_state_next = MOD_HDR;
            end
         end
         MOD_HDR: begin
            if (out_rdy) begin
               w_emit       = 1'b1;
               w_word       = {{(DATA_WIDTH-NUM_IQ_BITS){1'b0}}, r_src_port};
               w_ctrl       = CTRL_WIDTH'(MODULE_HDR_CTRL);
               w_state_next = HDR1;
            end
         end
         HDR1: begin
            if (out_rdy) begin
               w_emit       = 1'b1;
               w_word       = r_dst_mac[47:16];
               w_state_next = HDR2;
            end
         end
         HDR2: begin
            if (out_rdy) begin
               w_emit       = 1'b1;
               w_word       = {r_dst_mac[15:0], r_src_mac[47:32]};
               w_state_next = HDR3;
            end
         end
         HDR3: begin
            if (out_rdy) begin
               w_emit       = 1'b1;
               w_word       = r_src_mac[31:0];
               w_state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_accept) begin
               w_emit = 1'b1;
               w_word = w_rl_word;
               w_ctrl = w_rl_out_ctrl;
               if (w_rl_last)
                  w_state_next = w_rl_tail_req ? TAIL : IDLE;
`ifdef ETH_TX_PAD_EN
               if (w_rl_last && w_pad_needed) begin
                  w_ctrl       = w_last_slot ? CTRL_4B : CTRL_MID;
                  w_state_next = w_last_slot ? IDLE : PAD;
               end
`endif
            end
         end
         TAIL: begin
            if (out_rdy) begin
               w_emit       = 1'b1;
               w_word       = w_rl_tail_word;
               w_ctrl       = w_rl_tail_ctrl;
               w_state_next = IDLE;
            end
         end
`ifdef ETH_TX_PAD_EN
         PAD: begin
            if (out_rdy) begin
               w_emit = 1'b1;
               w_word = w_rl_tail_word;
               if (w_last_slot) begin
                  w_ctrl       = CTRL_4B;
                  w_state_next = IDLE;
               end
            end
         end
`endif
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dst_mac   <= 48'h0;
         r_src_mac   <= 48'h0;
         r_ethertype <= 16'h0;
         r_src_port  <= '0;
      end else if (w_capture) begin
         r_dst_mac   <= dst_mac;
         r_src_mac   <= src_mac;
         r_ethertype <= ethertype;
         r_src_port  <= src_port;
      end
   end

   // Data and ctrl hold their last value between strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data <= '0;
         out_ctrl <= '0;
         out_wr   <= 1'b0;
         hdr_ack  <= 1'b0;
      end else begin
         out_wr  <= w_emit;
         hdr_ack <= w_capture;
         if (w_emit) begin
            out_data <= w_word;
            out_ctrl <= w_ctrl;
         end
      end
   end

endmodule

// File: tb/tb_ethernet_header_writer_32bit.sv
// Directed bench for ethernet_header_writer_32bit; the padding scenario
// runs instead of the natural-length scenarios when ETH_TX_PAD_EN is defined.
module tb_ethernet_header_writer_32bit;

   logic        clk = 1'b0;
   logic        reset;
   logic        hdr_valid;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [15:0] ethertype;
   logic [2:0]  src_port;
   logic        hdr_ack;
   logic [31:0] in_data;
   logic [3:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic [31:0] out_data;
   logic [3:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;

   int checks = 0;
   int errors = 0;
   int ackCount = 0;
   int ackBefore;

   logic [31:0] gotData[$];
   logic [3:0]  gotCtrl[$];
   logic [31:0] expData[$];
   logic [3:0]  expCtrl[$];

   ethernet_header_writer_32bit dut (
      .clk       (clk),
      .reset     (reset),
      .hdr_valid (hdr_valid),
      .dst_mac   (dst_mac),
      .src_mac   (src_mac),
      .ethertype (ethertype),
      .src_port  (src_port),
      .hdr_ack   (hdr_ack),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .in_wr     (in_wr),
      .in_rdy    (in_rdy),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .out_wr    (out_wr),
      .out_rdy   (out_rdy)
   );

   always #5 clk = ~clk;

   // Capture emitted words and header acks half a cycle after each edge.
   always @(negedge clk) begin
      if (out_wr) begin
         gotData.push_back(out_data);
         gotCtrl.push_back(out_ctrl);
      end
      if (hdr_ack)
         ackCount++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expectWord(input logic [31:0] d, input logic [3:0] c);
      expData.push_back(d);
      expCtrl.push_back(c);
   endtask

   task automatic checkPacket(input string tag);
      checkOutput({tag, " word count"}, 32'(gotData.size()), 32'(expData.size()));
      for (int i = 0; i < expData.size(); i++) begin
         if (i < gotData.size()) begin
            checkOutput($sformatf("%s w%0d data", tag, i), gotData[i], expData[i]);
            checkOutput($sformatf("%s w%0d ctrl", tag, i), 32'(gotCtrl[i]), 32'(expCtrl[i]));
         end
      end
      gotData.delete();
      gotCtrl.delete();
      expData.delete();
      expCtrl.delete();
   endtask

   // Called at a negedge; returns at the negedge where hdr_ack is seen.
   task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s,
                                input logic [15:0] t, input logic [2:0] p);
      int n = 0;
      dst_mac   = d;
      src_mac   = s;
      ethertype = t;
      src_port  = p;
      hdr_valid = 1'b1;
      @(negedge clk);
      while (!hdr_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("hdr_ack seen", 32'(hdr_ack), 32'd1);
      hdr_valid = 1'b0;
   endtask

   // Holds one payload word until the writer accepts it.
   task automatic sendWord(input logic [31:0] d, input logic [3:0] c);
      int n = 0;
      in_wr   = 1'b1;
      in_data = d;
      in_ctrl = c;
      while (!in_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_rdy reached", 32'(in_rdy), 32'd1);
      @(negedge clk);
      in_wr   = 1'b0;
      in_ctrl = 4'h0;
   endtask

   task automatic expectHeader1();
      expectWord(32'h00000005, 4'h2);
      expectWord(32'h00112233, 4'h0);
      expectWord(32'h4455AABB, 4'h0);
      expectWord(32'hCCDDEEFF, 4'h0);
   endtask

   initial begin
      reset     = 1'b1;
      hdr_valid = 1'b0;
      dst_mac   = '0;
      src_mac   = '0;
      ethertype = '0;
      src_port  = '0;
      in_data   = '0;
      in_ctrl   = '0;
      in_wr     = 1'b0;
      out_rdy   = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("reset out_wr", 32'(out_wr), 32'd0);
      checkOutput("reset out_data", out_data, 32'd0);
      checkOutput("reset out_ctrl", 32'(out_ctrl), 32'd0);
      checkOutput("reset hdr_ack", 32'(hdr_ack), 32'd0);
      checkOutput("reset in_rdy", 32'(in_rdy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

`ifdef ETH_TX_PAD_EN
      ackBefore = ackCount;
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      sendWord(32'hDEAD0000, 4'h4);
      repeat (16) @(negedge clk);
      expectHeader1();
      expectWord(32'h0800DEAD, 4'h0);
      for (int i = 0; i < 10; i++)
         expectWord(32'h0, 4'h0);
      expectWord(32'h0, 4'h1);
      checkPacket("pad");
      checkOutput("pad ack count", 32'(ackCount - ackBefore), 32'd1);
`else
      $display("[TB] packet with two payload words and 4-byte tail");
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      sendWord(32'h01020304, 4'h0);
      sendWord(32'h05060708, 4'h1);
      repeat (4) @(negedge clk);
      expectHeader1();
      expectWord(32'h08000102, 4'h0);
      expectWord(32'h03040506, 4'h0);
      expectWord(32'h07080000, 4'h4);
      checkPacket("t1");

      $display("[TB] single 2-byte payload word");
      ackBefore = ackCount;
      applyStimulus(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 3'd3);
      sendWord(32'hDEAD0000, 4'h4);
      repeat (4) @(negedge clk);
      expectWord(32'h00000003, 4'h2);
      expectWord(32'h0A0B0C0D, 4'h0);
      expectWord(32'h0E0F1020, 4'h0);
      expectWord(32'h30405060, 4'h0);
      expectWord(32'h86DDDEAD, 4'h1);
      checkPacket("t2");
      checkOutput("t2 ack count", 32'(ackCount - ackBefore), 32'd1);
      checkOutput("t2 idle in_rdy", 32'(in_rdy), 32'd0);

      $display("[TB] last word with one valid byte");
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      sendWord(32'h11223344, 4'h0);
      sendWord(32'h55667788, 4'h8);
      repeat (4) @(negedge clk);
      expectHeader1();
      expectWord(32'h08001122, 4'h0);
      expectWord(32'h33445566, 4'h2);
      checkPacket("t3a");

      $display("[TB] last word with three valid bytes");
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      sendWord(32'hA1A2A3A4, 4'h2);
      repeat (4) @(negedge clk);
      expectHeader1();
      expectWord(32'h0800A1A2, 4'h0);
      expectWord(32'hA3A40000, 4'h8);
      checkPacket("t3b");

      $display("[TB] downstream stall while in HDR2");
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      @(negedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("t4 stall%0d out_wr", i), 32'(out_wr), 32'd0);
         checkOutput($sformatf("t4 stall%0d in_rdy", i), 32'(in_rdy), 32'd0);
      end
      out_rdy = 1'b1;
      sendWord(32'hCAFEF00D, 4'h1);
      repeat (4) @(negedge clk);
      expectHeader1();
      expectWord(32'h0800CAFE, 4'h0);
      expectWord(32'hF00D0000, 4'h4);
      checkPacket("t4");

      $display("[TB] reset in the middle of the payload");
      applyStimulus(48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800, 3'd5);
      sendWord(32'h12345678, 4'h0);
      reset = 1'b1;
      #1;
      checkOutput("t5 reset out_wr", 32'(out_wr), 32'd0);
      checkOutput("t5 reset out_data", out_data, 32'd0);
      checkOutput("t5 reset in_rdy", 32'(in_rdy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      gotData.delete();
      gotCtrl.delete();
      @(negedge clk);
      applyStimulus(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 3'd3);
      sendWord(32'hDEAD0000, 4'h4);
      repeat (4) @(negedge clk);
      expectWord(32'h00000003, 4'h2);
      expectWord(32'h0A0B0C0D, 4'h0);
      expectWord(32'h0E0F1020, 4'h0);
      expectWord(32'h30405060, 4'h0);
      expectWord(32'h86DDDEAD, 4'h1);
      checkPacket("t5 clean");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
